rx_module: RTL and testbench
============================

Name: rx_module

Overview:
- UART receive stage; consumes the serial stream produced by tx_module (`uart_tx_o` → `uart_rx_i`).
- Oversamples the line using the shared baud-enable tick, at 2^SAMPLE_COUNTER_WIDTH ticks per bit.
- Delivers a parallel word with a done pulse plus parity and framing error flags.
- Uses the same configuration word format as tx_module, so one register can drive both.

Parameters:
- MAX_DATA_WIDTH, 8: width of `rx_data_o`; largest supported data length.
- DATA_COUNTER_WIDTH, 3: width of the received-bit index counter.
- STOP_CONF_WIDTH, 2: width of the stop-bit field in `rx_conf_i`.
- DATA_CONF_WIDTH, 2: width of the data-length field in `rx_conf_i`.
- SAMPLE_COUNTER_WIDTH, 4: oversample counter width; 16 ticks per bit at default.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- baud_en_i  in  1  single-cycle oversample tick.
- rx_en_i  in  1  receiver enable.
- rx_conf_i  in  STOP_CONF_WIDTH+DATA_CONF_WIDTH+1  frame configuration:
  - [4:3] data length: 00=5, 01=6, 10=7, 11=8 bits.
  - [2:1] stop bits: 00=1 stop bit; any other value = 2 stop bits.
  - [0] parity: 1 = even parity bit present, 0 = none.
- uart_rx_i  in  1  asynchronous serial input; idle level is high.
- rx_data_o  out  MAX_DATA_WIDTH  received word, LSB-first assembly, right-aligned, unused upper bits 0.
- rx_done_o  out  1  one-cycle pulse; frame complete.
- busy_o  out  1  high while not IDLE.
- parity_err_o  out  1  parity mismatch on last frame.
- frame_err_o  out  1  a stop bit sampled low on last frame.

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0, synchroniser flops are 1.
- Synchroniser: `uart_rx_i` passes through 2 flops; all decisions use the synchronised value `rx_s`.
- Counters and FSM advance only in cycles where `baud_en_i` = 1; they hold otherwise.
- Define MID = 2^(SAMPLE_COUNTER_WIDTH-1)-1 (7 at default) and LAST = all-ones (15 at default).
- IDLE:
  - Transition: `rx_en_i`=1 and a tick with `rx_s`=0 → START.
  - On that transition: clear the sample counter, latch `rx_conf_i` into an internal register, clear the bit index.
- START:
  - Counter increments each tick.
  - When the counter reaches MID on a tick, sample the line.
  - Sample = 0 → DATA, counter cleared.
  - Sample = 1 → false start, back to IDLE with no done pulse and no flag change.
- DATA:
  - Counter increments each tick.
  - On the tick where the counter = LAST, sample `rx_s` into the shift register at the bit index, then increment the index; the counter wraps to 0.
  - After the bit at index (length-1) is sampled: go to PARITY if parity is enabled, else go to STOP.
- PARITY:
  - Same sampling rule as DATA.
  - Error condition: XOR of the data bits and the parity bit is 1.
  - → STOP.
- STOP:
  - Same sampling rule as DATA.
  - Any stop sample of 0 sets the pending frame error.
  - After the final stop sample (1st or 2nd, per config): go to IDLE.
- Completion:
  - In the clock after the final stop sample, `rx_done_o`=1 for exactly 1 cycle.
  - In that same cycle, `rx_data_o`, `parity_err_o` and `frame_err_o` update.
  - These outputs hold until the next completed frame.
- busy_o: 1 from the cycle after start detection until the cycle in which `rx_done_o` pulses; it is 0 in that cycle. After a false start, `busy_o` drops the cycle after the MID sample.
- `rx_en_i` low mid-frame: abort to IDLE next cycle, no done pulse, outputs keep their previous values.
- `rx_conf_i` changes mid-frame are ignored because the config is latched.
- Frame error does not suppress data: the done pulse still occurs.
- Break (line held low): completes with frame error, then waits in IDLE for the line to go high before a new start can be accepted.
- Reset mid-frame: returns immediately (asynchronously) to reset values.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - conf field bit positions;
  - data-length decode function;
  - stop-count decode function;
  - TotalConfWidth constant.
- tx_module uses the same package.
- One sub-module: `sync_2ff` (parameterised reset value, reset value 1 here).

Test Plan:
- Loopback: tx_module → rx_module, conf 5'b11000, data 8'hAA, baud tick every clock → one `rx_done_o` pulse, `rx_data_o`=8'hAA, both errors 0.
- conf 5'b10001 (7 bits, even parity), data 7'h55 sent with parity 0 → `rx_data_o`=8'h55, `parity_err_o`=0; repeat with parity bit forced to 1 → same data, `parity_err_o`=1.
- conf 5'b11010 (8 bits, 2 stop), data 8'h3C, second stop bit driven low → `rx_data_o`=8'h3C, `frame_err_o`=1, one done pulse.
- False start: line low for 4 ticks, then high → no done pulse, `busy_o` back to 0 after tick 8, outputs unchanged.
- Reset asserted at the 3rd data bit → all outputs 0 at once; after reset lifts, the next frame with 8'h81 (conf 5'b11000) is received correctly.
- `rx_en_i` dropped mid-frame → no done pulse, `busy_o`=0 next cycle; re-enabled, frame 5'b00000 with data 5'h15 → `rx_data_o`=8'h15.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, configuration-word layout and the
// decode helpers used by both the transmit and receive stages.
package uart_pkg;

  // Frame sequencing states common to tx_module and rx_module.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Configuration word layout: {data_len[1:0], stop[1:0], parity_en}.
  localparam int unsigned DataConfWidth  = 2;
  localparam int unsigned StopConfWidth  = 2;
  localparam int unsigned TotalConfWidth = DataConfWidth + StopConfWidth + 1;
  localparam int unsigned ConfParityBit  = 0;
  localparam int unsigned ConfStopLsb    = 1;

  // Shortest supported data length; the data field adds to this.
  localparam int unsigned MinDataLen = 5;

  // Data-length field to number of data bits (00=5 ... 11=8).
  function automatic int unsigned data_len(input logic [DataConfWidth-1:0] field);
    return MinDataLen + 32'(field);
  endfunction

  // Stop field to number of stop bits: zero means one, anything else two.
  function automatic int unsigned stop_count(input logic [StopConfWidth-1:0] field);
    return (field == '0) ? 1 : 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input, with a configurable
// reset value so an idle-high line does not look active during reset.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the input one stage per clock through the two flops.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchroniser register pair; reset to the line's idle level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source and the two stages cannot collapse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rx_module.sv
// UART receiver: oversamples the synchronised line on baud ticks, assembles
// an LSB-first word and reports it with a done pulse plus error flags.
module rx_module
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_WIDTH       = 8,
  parameter int unsigned DATA_COUNTER_WIDTH   = 3,
  parameter int unsigned STOP_CONF_WIDTH      = StopConfWidth,
  parameter int unsigned DATA_CONF_WIDTH      = DataConfWidth,
  parameter int unsigned SAMPLE_COUNTER_WIDTH = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      baud_en_i,
  input  logic                                      rx_en_i,
  input  logic [STOP_CONF_WIDTH+DATA_CONF_WIDTH:0]  rx_conf_i,
  input  logic                                      uart_rx_i,
  output logic [MAX_DATA_WIDTH-1:0]                 rx_data_o,
  output logic                                      rx_done_o,
  output logic                                      busy_o,
  output logic                                      parity_err_o,
  output logic                                      frame_err_o
);

  localparam int unsigned ConfW = STOP_CONF_WIDTH + DATA_CONF_WIDTH + 1;

  // Start bit is confirmed half a bit after the falling edge; every later
  // bit is sampled one full bit period after the previous sample.
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] Mid  =
    {1'b0, {(SAMPLE_COUNTER_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_COUNTER_WIDTH-1:0] Last = '1;

  logic rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (uart_rx_i),
    .q_o   (rx_s)
  );

  // Frame sequencing state
  uart_state_e                     state_q, state_d;
  logic [SAMPLE_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_COUNTER_WIDTH-1:0]   idx_q, idx_d;
  logic [ConfW-1:0]                conf_q, conf_d;
  logic [MAX_DATA_WIDTH-1:0]       shift_q, shift_d;
  logic                            perr_pend_q, perr_pend_d;
  logic                            ferr_pend_q, ferr_pend_d;
  // Cleared when a frame ends on a low stop sample (break); a new start is
  // only accepted once the line has been seen high again in IDLE.
  logic                            armed_q, armed_d;

  // Registered outputs, held between completed frames
  logic [MAX_DATA_WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                            done_q, done_d;
  logic                            perr_q, perr_d;
  logic                            ferr_q, ferr_d;

  // Frame shape decoded from the configuration latched at start detection
  logic [DATA_COUNTER_WIDTH-1:0]   last_data_idx;
  logic [DATA_COUNTER_WIDTH-1:0]   last_stop_idx;
  logic                            parity_en;

  assign last_data_idx = DATA_COUNTER_WIDTH'(
    data_len(conf_q[TotalConfWidth-1 -: DATA_CONF_WIDTH]) - 1);
  assign last_stop_idx = DATA_COUNTER_WIDTH'(
    stop_count(conf_q[ConfStopLsb +: STOP_CONF_WIDTH]) - 1);
  assign parity_en     = conf_q[ConfParityBit];

  // Next-state, counter, shift-register and output-register logic.
  // NOTE: every signal gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    conf_d      = conf_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    if (state_q == ST_IDLE && rx_s) begin
      armed_d = 1'b1;
    end

    if (state_q != ST_IDLE && !rx_en_i) begin
      // Disabled mid-frame: drop the frame without touching the outputs.
      state_d = ST_IDLE;
    end else if (baud_en_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_en_i && armed_q && !rx_s) begin
            state_d     = ST_START;
            cnt_d       = '0;
            idx_d       = '0;
            conf_d      = rx_conf_i;
            shift_d     = '0;
            perr_pend_d = 1'b0;
            ferr_pend_d = 1'b0;
          end
        end

        ST_START: begin
          if (cnt_q == Mid) begin
            cnt_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == Last) begin
            shift_d[idx_q] = rx_s;
            if (idx_q == last_data_idx) begin
              idx_d   = '0;
              state_d = parity_en ? ST_PARITY : ST_STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == Last) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            perr_pend_d = (^shift_q) ^ rx_s;
            idx_d       = '0;
            state_d     = ST_STOP;
          end
        end

        ST_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == Last) begin
            if (!rx_s) begin
              ferr_pend_d = 1'b1;
            end
            if (idx_q == last_stop_idx) begin
              state_d   = ST_IDLE;
              done_d    = 1'b1;
              rx_data_d = shift_q;
              perr_d    = perr_pend_q;
              ferr_d    = ferr_pend_q | ~rx_s;
              armed_d   = rx_s;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      conf_q      <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      armed_q     <= 1'b0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      conf_q      <= conf_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_done_o    = done_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_rx_module.sv
// Self-checking bench for rx_module: a serial frame generator drives the
// line, a table of directed frames and a randomized run are compared with a
// frame-level model, and hand-written sequences cover the corner cases.
module tb_rx_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_en;
  logic       rx_en;
  logic [4:0] rx_conf;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       busy;
  logic       perr;
  logic       ferr;

  always #5 clk = ~clk;

  rx_module dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .baud_en_i    (baud_en),
    .rx_en_i      (rx_en),
    .rx_conf_i    (rx_conf),
    .uart_rx_i    (uart_rx),
    .rx_data_o    (rx_data),
    .rx_done_o    (rx_done),
    .busy_o       (busy),
    .parity_err_o (perr),
    .frame_err_o  (ferr)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [4:0] conf;
    logic [7:0] data;
    logic       flip;      // invert the correct even-parity bit
    logic [1:0] stop_low;  // per stop bit: drive it low
    logic       scramble;  // change rx_conf after the start bit
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   baud_div = 1;
  int   phase = 0;
  logic line_v = 1'b1;
  int   done_cnt = 0;
  int   dbl_pulse = 0;
  int   busy_at_done = 0;
  logic done_prev = 1'b0;
  exp_t last_exp = '0;
  vec_t vecs [11];

  // Watch the done pulse: count it, and flag pulses longer than one cycle
  // or pulses that coincide with busy.
  always @(negedge clk) begin
    if (rx_done && done_prev) dbl_pulse++;
    if (rx_done && busy) busy_at_done++;
    if (rx_done) done_cnt++;
    done_prev = rx_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus, applied on the falling edge.
  task automatic cyc();
    @(negedge clk);
    baud_en = (phase == 0);
    phase   = (phase + 1) % baud_div;
    uart_rx = line_v;
  endtask

  // Hold the line at v for n baud ticks.
  task automatic hold(input logic v, input int n_ticks);
    int t;
    t = 0;
    line_v = v;
    while (t < n_ticks) begin
      cyc();
      if (baud_en) t++;
    end
  endtask

  // Frame-level reference: what a receiver must report for a frame.
  function automatic exp_t model(input logic [4:0] conf, input logic [7:0] data,
                                 input logic flip, input logic [1:0] stop_low);
    exp_t e;
    int   len;
    int   ones;
    int   pbit;
    len    = 5 + int'(conf[4:3]);
    e.data = data & 8'((1 << len) - 1);
    ones   = $countones(e.data);
    pbit   = (ones % 2) ^ int'(flip);
    e.perr = conf[0] ? (((ones + pbit) % 2) == 1) : 1'b0;
    e.ferr = stop_low[0] || ((conf[2:1] != 2'b00) && stop_low[1]);
    return e;
  endfunction

  task automatic send_frame(input logic [4:0] conf, input logic [7:0] data,
                            input logic flip, input logic [1:0] stop_low,
                            input logic scramble);
    int len;
    int nstop;
    len   = 5 + int'(conf[4:3]);
    nstop = (conf[2:1] == 2'b00) ? 1 : 2;
    rx_conf = conf;
    hold(1'b0, 16);
    if (scramble) rx_conf = ~conf;
    for (int i = 0; i < len; i++) hold(data[i], 16);
    if (conf[0]) hold(^(data & 8'((1 << len) - 1)) ^ flip, 16);
    for (int s = 0; s < nstop; s++) hold(~stop_low[s], 16);
    hold(1'b1, 32);
  endtask

  task automatic run_frame(input string name, input logic [4:0] conf, input logic [7:0] data,
                           input logic flip, input logic [1:0] stop_low, input logic scramble,
                           input exp_t e);
    int base;
    base = done_cnt;
    send_frame(conf, data, flip, stop_low, scramble);
    check({name, " done count"}, done_cnt - base, 1);
    check({name, " data"}, rx_data, e.data);
    check({name, " parity_err"}, perr, e.perr);
    check({name, " frame_err"}, ferr, e.ferr);
    check({name, " busy after"}, busy, 0);
    last_exp = e;
  endtask

  initial begin
    int   base;
    exp_t e;
    logic [4:0] c;
    logic [7:0] d;
    logic       f;
    logic [1:0] sl;

    vecs[0]  = '{5'b11000, 8'hAA, 1'b0, 2'b00, 1'b0, 8'hAA, 1'b0, 1'b0};
    vecs[1]  = '{5'b10001, 8'h55, 1'b0, 2'b00, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[2]  = '{5'b10001, 8'h55, 1'b1, 2'b00, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[3]  = '{5'b11010, 8'h3C, 1'b0, 2'b10, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4]  = '{5'b00000, 8'h15, 1'b0, 2'b00, 1'b0, 8'h15, 1'b0, 1'b0};
    vecs[5]  = '{5'b00000, 8'hFF, 1'b0, 2'b00, 1'b0, 8'h1F, 1'b0, 1'b0};
    vecs[6]  = '{5'b00001, 8'h1F, 1'b0, 2'b00, 1'b0, 8'h1F, 1'b0, 1'b0};
    vecs[7]  = '{5'b01110, 8'h3F, 1'b0, 2'b01, 1'b0, 8'h3F, 1'b0, 1'b1};
    vecs[8]  = '{5'b11011, 8'h81, 1'b1, 2'b11, 1'b0, 8'h81, 1'b1, 1'b1};
    vecs[9]  = '{5'b10000, 8'h7F, 1'b0, 2'b00, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[10] = '{5'b01000, 8'hC3, 1'b0, 2'b00, 1'b0, 8'h03, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1; baud_en = 1'b0; rx_en = 1'b0; rx_conf = '0; uart_rx = 1'b1;
    repeat (3) cyc();
    check("reset data", rx_data, 0);
    check("reset done", rx_done, 0);
    check("reset busy", busy, 0);
    check("reset perr", perr, 0);
    check("reset ferr", ferr, 0);
    rst = 1'b0;
    rx_en = 1'b1;
    hold(1'b1, 32);

    // Directed frame table
    for (int i = 0; i < 11; i++) begin
      e.data = vecs[i].exp_data;
      e.perr = vecs[i].exp_perr;
      e.ferr = vecs[i].exp_ferr;
      run_frame($sformatf("vec%0d", i), vecs[i].conf, vecs[i].data, vecs[i].flip,
                vecs[i].stop_low, vecs[i].scramble, e);
    end

    // False start: low for 4 ticks, then high
    base = done_cnt;
    hold(1'b0, 4);
    hold(1'b1, 2);
    check("false start busy during", busy, 1);
    hold(1'b1, 10);
    check("false start busy after", busy, 0);
    check("false start no done", done_cnt - base, 0);
    check("false start data kept", rx_data, last_exp.data);
    check("false start perr kept", perr, last_exp.perr);
    check("false start ferr kept", ferr, last_exp.ferr);

    // Reset during the third data bit
    rx_conf = 5'b11000;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 8);
    check("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid reset data", rx_data, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", rx_done, 0);
    check("mid reset perr", perr, 0);
    check("mid reset ferr", ferr, 0);
    repeat (3) cyc();
    rst = 1'b0;
    hold(1'b1, 32);
    run_frame("after reset", 5'b11000, 8'h81, 1'b0, 2'b00, 1'b0, model(5'b11000, 8'h81, 1'b0, 2'b00));

    // Receiver disabled mid-frame
    base = done_cnt;
    rx_conf = 5'b11000;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    check("abort busy before", busy, 1);
    rx_en = 1'b0;
    cyc();
    check("abort busy next cycle", busy, 0);
    hold(1'b1, 40);
    rx_en = 1'b1;
    hold(1'b1, 16);
    check("abort no done", done_cnt - base, 0);
    check("abort data kept", rx_data, last_exp.data);
    run_frame("after abort", 5'b00000, 8'h15, 1'b0, 2'b00, 1'b0, model(5'b00000, 8'h15, 1'b0, 2'b00));

    // Break: line held low through a whole frame and beyond
    base = done_cnt;
    rx_conf = 5'b11000;
    hold(1'b0, 200);
    check("break done", done_cnt - base, 1);
    check("break data", rx_data, 0);
    check("break ferr", ferr, 1);
    check("break perr", perr, 0);
    check("break busy", busy, 0);
    hold(1'b0, 100);
    check("break no restart done", done_cnt - base, 1);
    check("break no restart busy", busy, 0);
    hold(1'b1, 32);
    run_frame("after break", 5'b11000, 8'hA5, 1'b0, 2'b00, 1'b0, model(5'b11000, 8'hA5, 1'b0, 2'b00));

    // Randomized frames against the model, varying the tick rate
    for (int n = 0; n < 40; n++) begin
      baud_div = $urandom_range(1, 3);
      phase    = 0;
      c  = 5'($urandom);
      d  = 8'($urandom);
      f  = ($urandom_range(0, 3) == 0);
      sl = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      run_frame($sformatf("rand%0d c=%b d=%h", n, c, d), c, d, f, sl, 1'b0, model(c, d, f, sl));
    end
    baud_div = 1;
    phase    = 0;

    check("done pulse width", dbl_pulse, 0);
    check("busy low at done", busy_at_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
